// File: rtl/flag_branch_unit.sv
// Flag register with same-cycle bypass, conditional branch resolution and a
// fixed-length pipeline flush after every taken branch.
module flag_branch_unit #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      flags_in,
  input  logic            flags_we,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic [1:0]      flags_q,
  output logic            take_branch,
  output logic [PC_W-1:0] branch_pc,
  output logic            flush,
  output logic            busy,
  output logic [15:0]     taken_cnt,
  output logic            state_dbg
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      flags_d;
  logic            take_d;
  logic [PC_W-1:0] pc_d;
  logic [15:0]     tcnt_d;
  logic [1:0]      eff_flags;
  logic            cond_true;
  logic            accept;

  // Handshake: a branch is consumed only when br_valid=1, stall=0 and the
  // unit is IDLE; any other br_valid is dropped with no side effect.
  always_comb begin
    eff_flags = flags_we ? flags_in : flags_q;
    cond_true = 1'b0;
    case (br_cond)
      3'd0:    cond_true = eff_flags[0];
      3'd1:    cond_true = ~eff_flags[0];
      3'd2:    cond_true = eff_flags[1];
      3'd3:    cond_true = ~eff_flags[1];
      3'd4:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    accept = br_valid && !stall && (state_q == IDLE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    take_d  = take_branch;
    pc_d    = branch_pc;
    tcnt_d  = taken_cnt;
    if (!stall) begin
      if (flags_we) flags_d = flags_in;
      take_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && cond_true) begin
            state_d = FLUSH;
            cnt_d   = 3'(FLUSH_CYCLES);
            take_d  = 1'b1;
            pc_d    = br_target;
            tcnt_d  = (taken_cnt == 16'hFFFF) ? taken_cnt : taken_cnt + 16'd1;
          end
        end
        FLUSH: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The counter register is written every cycle (holding its value under
  // stall) so the saturating count always reflects the last stored value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      flags_q     <= 2'b00;
      take_branch <= 1'b0;
      branch_pc   <= '0;
      taken_cnt   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      take_branch <= take_d;
      branch_pc   <= pc_d;
      taken_cnt   <= tcnt_d;
    end
  end

  assign flush     = (state_q == FLUSH);
  assign busy      = (state_q == FLUSH);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: vector table, hand-written corner sequences and
// random stimulus checked against a cycle-level behavioural model.
module tb_flag_branch_unit;

  localparam int PC_W = 32;
  localparam int FC   = 2;

  logic            clk;
  logic            rst;
  logic            stall;
  logic [1:0]      flags_in;
  logic            flags_we;
  logic            br_valid;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic [1:0]      flags_q;
  logic            take_branch;
  logic [PC_W-1:0] branch_pc;
  logic            flush;
  logic            busy;
  logic [15:0]     taken_cnt;
  logic            state_dbg;

  flag_branch_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flags_in(flags_in),
    .flags_we(flags_we), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .flags_q(flags_q), .take_branch(take_branch),
    .branch_pc(branch_pc), .flush(flush), .busy(busy),
    .taken_cnt(taken_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model: remaining flush cycles as a plain integer
  int              m_rem;
  logic            m_take;
  logic [1:0]      m_flags;
  logic [PC_W-1:0] m_pc;
  int              m_cnt;

  typedef struct {
    logic            s;
    logic            we;
    logic [1:0]      fi;
    logic            bv;
    logic [2:0]      c;
    logic [PC_W-1:0] t;
    logic            e_take;
    logic            e_flush;
    logic [1:0]      e_flags;
    logic [15:0]     e_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_met(input logic [2:0] c, input logic [1:0] f);
    // Z = f[0], N = f[1]
    if (c == 3'd4) return 1'b1;
    if (c > 3'd4) return 1'b0;
    return (c[1] ? f[1] : f[0]) == !c[0];
  endfunction

  task automatic model_reset();
    m_rem = 0; m_take = 0; m_flags = 2'b00; m_pc = '0; m_cnt = 0;
  endtask

  task automatic model_step(input logic s, input logic we, input logic [1:0] fi,
                            input logic bv, input logic [2:0] c, input logic [PC_W-1:0] t);
    logic [1:0] eff;
    if (s) return;
    eff = we ? fi : m_flags;
    if (we) m_flags = fi;
    m_take = 1'b0;
    if (m_rem > 0) m_rem--;
    else if (bv && cond_met(c, eff)) begin
      m_take = 1'b1;
      m_rem  = FC;
      m_pc   = t;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_model();
    chk("take_branch", 32'(take_branch), 32'(m_take));
    chk("flush", 32'(flush), 32'(m_rem > 0));
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("state_dbg", 32'(state_dbg), 32'(m_rem > 0));
    chk("flags_q", 32'(flags_q), 32'(m_flags));
    chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    chk("branch_pc", 32'(branch_pc), 32'(m_pc));
  endtask

  // driver: apply one cycle of inputs at negedge, check after the posedge
  task automatic cycle(input logic s, input logic we, input logic [1:0] fi,
                       input logic bv, input logic [2:0] c, input logic [PC_W-1:0] t);
    stall = s; flags_we = we; flags_in = fi; br_valid = bv; br_cond = c; br_target = t;
    model_step(s, we, fi, bv, c, t);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, '0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 2'b01, 1'b1, 3'd0, 32'h100, 1'b1, 1'b1, 2'b01, 16'd1};
    tbl[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'h200, 1'b0, 1'b1, 2'b01, 16'd1};
    tbl[2]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 32'h000, 1'b0, 1'b0, 2'b01, 16'd1};
    tbl[3]  = '{1'b0, 1'b1, 2'b10, 1'b1, 3'd3, 32'h2F0, 1'b0, 1'b0, 2'b10, 16'd1};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'd2, 32'h300, 1'b1, 1'b1, 2'b10, 16'd2};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 32'h000, 1'b0, 1'b1, 2'b10, 16'd2};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'h3F0, 1'b0, 1'b0, 2'b10, 16'd2};
    tbl[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'h400, 1'b1, 1'b1, 2'b10, 16'd3};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 32'h000, 1'b0, 1'b1, 2'b10, 16'd3};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 32'h000, 1'b0, 1'b0, 2'b10, 16'd3};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'd5, 32'h500, 1'b0, 1'b0, 2'b10, 16'd3};
    tbl[11] = '{1'b0, 1'b1, 2'b11, 1'b1, 3'd6, 32'h600, 1'b0, 1'b0, 2'b11, 16'd3};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'd7, 32'h700, 1'b0, 1'b0, 2'b11, 16'd3};
    tbl[13] = '{1'b0, 1'b1, 2'b00, 1'b1, 3'd1, 32'h800, 1'b1, 1'b1, 2'b00, 16'd4};

    rst = 1'b0; stall = 1'b0; flags_in = 2'b00; flags_we = 1'b0;
    br_valid = 1'b0; br_cond = 3'd0; br_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    rst = 1'b1;

    // vector table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].s, tbl[i].we, tbl[i].fi, tbl[i].bv, tbl[i].c, tbl[i].t);
      chk($sformatf("vec%0d_take", i), 32'(take_branch), 32'(tbl[i].e_take));
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      chk($sformatf("vec%0d_flags", i), 32'(flags_q), 32'(tbl[i].e_flags));
      chk($sformatf("vec%0d_cnt", i), 32'(taken_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_take) chk($sformatf("vec%0d_pc", i), branch_pc, tbl[i].t);
    end
    idle(); idle();

    // stall during flush: everything frozen, unstalled flush length unchanged
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'hA00);
    chk("stall_take0", 32'(take_branch), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 32'hB00);
      chk("stall_take_held", 32'(take_branch), 32'd1);
      chk("stall_flush_held", 32'(flush), 32'd1);
      chk("stall_pc_held", branch_pc, 32'hA00);
    end
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, '0);
    chk("stall_flush_2nd", 32'(flush), 32'd1);
    chk("stall_take_drop", 32'(take_branch), 32'd0);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, '0);
    chk("stall_flush_end", 32'(flush), 32'd0);
    chk("stall_cnt", 32'(taken_cnt), 32'd5);

    // asynchronous reset in the middle of a flush
    cycle(1'b0, 1'b1, 2'b11, 1'b1, 3'd0, 32'hC00);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_take", 32'(take_branch), 32'd0);
    chk("rst_pc", branch_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'hD00);
    chk("post_rst_take", 32'(take_branch), 32'd1);
    idle(); idle();

    // saturation: preload the counter to 0xFFFE
    force dut.taken_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    idle();
    release dut.taken_cnt;
    #1;
    chk("sat_preload", 32'(taken_cnt), 32'hFFFE);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'hE00);
    chk("sat_first", 32'(taken_cnt), 32'hFFFF);
    idle(); idle();
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 32'hF00);
    chk("sat_second", 32'(taken_cnt), 32'hFFFF);
    idle(); idle();

    // reserved condition codes with every flag combination
    for (int f = 0; f < 4; f++)
      for (int c = 5; c < 8; c++) begin
        cycle(1'b0, 1'b1, 2'(f), 1'b1, 3'(c), 32'h1234);
        chk("reserved_take", 32'(take_branch), 32'd0);
      end

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), PC_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, branch target width in bits.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1-7, number of cycles flush is held after a taken branch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  pipeline stall; freezes all state while high.
REQ-006 SHALL have port flags_in  input  2  flags from the flag generator; [0]=zero, [1]=negative.
REQ-007 SHALL have port flags_we  input  1  flags_in is valid this cycle.
REQ-008 SHALL have port br_valid  input  1  a branch is presented this cycle.
REQ-009 SHALL have port br_cond  input  3  branch condition code.
REQ-010 SHALL have port br_target  input  PC_W  branch destination address.
REQ-011 SHALL have port flags_q  output  2  architectural flag register.
REQ-012 SHALL have port take_branch  output  1  one-cycle pulse: redirect PC.
REQ-013 SHALL have port branch_pc  output  PC_W  registered target, valid while take_branch=1.
REQ-014 SHALL have port flush  output  1  squash younger pipeline instructions.
REQ-015 SHALL have port busy  output  1  unit is in FLUSH state; branches not accepted.
REQ-016 SHALL have port taken_cnt  output  16  saturating count of taken branches.

Function
REQ-017 SHALL update flags_q <= flags_in on a clock edge when flags_we=1 and stall=0; otherwise hold.
REQ-018 SHALL form effective flags: flags_in when flags_we=1, else flags_q (same-cycle bypass).
REQ-019 SHALL decode br_cond against effective flags: 0 taken if Z=1; 1 if Z=0; 2 if N=1; 3 if N=0; 4 always; 5-7 never.
REQ-020 SHALL accept a branch in a cycle only when br_valid=1, stall=0 and state=IDLE; all other br_valid are ignored with no side effect.
REQ-021 SHALL implement FSM states IDLE and FLUSH; reset state IDLE.
REQ-022 SHALL transition IDLE->FLUSH on the edge ending an accepted taken branch, load a down-counter with FLUSH_CYCLES, and register branch_pc <= br_target.
REQ-023 SHALL assert take_branch for exactly the first cycle after acceptance (latency 1), and flush and busy for FLUSH_CYCLES cycles starting that same cycle.
REQ-024 SHALL decrement the counter each unstalled cycle in FLUSH and return to IDLE on the edge where it reaches zero; during stall, state, counter, take_branch, flush and branch_pc are held.
REQ-025 SHALL leave outputs unchanged for an accepted not-taken branch (state stays IDLE).
REQ-026 SHALL increment taken_cnt on each accepted taken branch, saturating at 16'hFFFF.
REQ-027 SHALL still update flags_q per REQ-017 while in FLUSH.
REQ-028 SHALL, if a branch is accepted in the same cycle the FSM returns to IDLE, treat it normally (no bubble required).

Reset
REQ-029 SHALL, when rst=0 at any time (including mid-FLUSH), immediately force flags_q=0, take_branch=0, branch_pc=0, flush=0, busy=0, taken_cnt=0, counter=0, state=IDLE.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Verification
REQ-031 Bypass: flags_q=2'b00, same cycle flags_we=1 flags_in=2'b01, br_valid=1 br_cond=0 target=0x100 -> next cycle take_branch=1, branch_pc=0x100, flags_q=2'b01.
REQ-032 Flush length: FLUSH_CYCLES=2, taken branch at t -> flush=1 and busy=1 at t+1,t+2, low at t+3; br_valid at t+1 ignored, taken_cnt increments only once.
REQ-033 Not taken: flags_q=2'b10, br_cond=3 -> take_branch, flush stay 0, taken_cnt unchanged; br_cond=2 next cycle -> take_branch=1.
REQ-034 Stall: taken branch accepted, stall=1 for 3 cycles starting t+1 -> take_branch, flush and counter held; flush total unstalled duration still FLUSH_CYCLES.
REQ-035 Reset mid-flush: rst=0 during FLUSH -> flush=0, busy=0, flags_q=0, taken_cnt=0 immediately, without waiting for a clock edge.
REQ-036 Saturation and reserved codes: taken_cnt preloaded to 0xFFFE, two taken branches -> 0xFFFF; br_cond=5-7 with any flags -> never taken.
